// File: rtl/sync_axis_cntr.sv
// Timing-axis counter for the VGA sync generator.
// Counts 0..total, decodes blank/active/sync from the count, and emits
// frame-wrap and line-match pulses. Timing fields are double-buffered:
// a committed configuration sits in staging until the next wrap, where it
// is validated and either adopted into the shadow fields or rejected.
module sync_axis_cntr #(
  parameter int W              = 10,
  parameter bit SYNC_POL       = 1'b0,
  parameter int DEF_VISIBLE    = 480,
  parameter int DEF_SYNC_START = 490,
  parameter int DEF_SYNC_END   = 492,
  parameter int DEF_TOTAL      = 524
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           adv,
  input  logic [4*W-1:0] cfg,
  input  logic           cfg_commit,
  input  logic [W-1:0]   match_line,
  output logic [W-1:0]   count,
  output logic           blank,
  output logic           active,
  output logic           sync,
  output logic           wrap,
  output logic           line_match,
  output logic           cfg_pending,
  output logic           cfg_err
);

  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   vis_q, vis_d;
  logic [W-1:0]   ss_q, ss_d;
  logic [W-1:0]   se_q, se_d;
  logic [W-1:0]   tot_q, tot_d;
  logic [4*W-1:0] stage_q, stage_d;
  logic           pending_q, pending_d;
  logic           err_q, err_d;
  logic           wrap_q, wrap_d;
  logic           match_q, match_d;
  logic           blank_q, blank_d;
  logic           sync_q, sync_d;

  logic           wrap_evt;
  logic           stage_valid;
  logic [W-1:0]   stg_vis, stg_ss, stg_se, stg_tot;

  assign stg_vis = stage_q[W-1:0];
  assign stg_ss  = stage_q[2*W-1:W];
  assign stg_se  = stage_q[3*W-1:2*W];
  assign stg_tot = stage_q[4*W-1:3*W];

  // Advance the position and detect the wrap event (last count reached while advancing)
  always_comb begin
    wrap_evt = adv && (count_q == tot_q);
    count_d  = count_q;
    if (adv) begin
      count_d = wrap_evt ? '0 : count_q + W'(1);
    end
  end

  // Staging/shadow handshake: apply (or reject) staging at wrap, then capture any new commit
  always_comb begin
    stage_valid = (stg_vis <= stg_ss) && (stg_ss < stg_se) &&
                  (stg_se <= stg_tot) && (stg_tot != '0);
    vis_d     = vis_q;
    ss_d      = ss_q;
    se_d      = se_q;
    tot_d     = tot_q;
    err_d     = err_q;
    pending_d = pending_q;
    stage_d   = stage_q;
    if (wrap_evt && pending_q) begin
      if (stage_valid) begin
        vis_d = stg_vis;
        ss_d  = stg_ss;
        se_d  = stg_se;
        tot_d = stg_tot;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      pending_d = 1'b0;
    end
    if (cfg_commit) begin
      stage_d   = cfg;
      pending_d = 1'b1;
    end
  end

  // Decode flags and pulses from the next count and next shadow so they line up with count
  always_comb begin
    wrap_d  = wrap_evt;
    match_d = adv && (count_d == match_line);
    blank_d = (count_d >= vis_d);
    sync_d  = ((count_d >= ss_d) && (count_d < se_d)) ? SYNC_POL : ~SYNC_POL;
  end

  // State register; reset restores the default timing and discards any staged commit
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q   <= '0;
      vis_q     <= W'(DEF_VISIBLE);
      ss_q      <= W'(DEF_SYNC_START);
      se_q      <= W'(DEF_SYNC_END);
      tot_q     <= W'(DEF_TOTAL);
      stage_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      match_q   <= 1'b0;
      blank_q   <= 1'b0;
      sync_q    <= ~SYNC_POL;
    end else begin
      count_q   <= count_d;
      vis_q     <= vis_d;
      ss_q      <= ss_d;
      se_q      <= se_d;
      tot_q     <= tot_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      match_q   <= match_d;
      blank_q   <= blank_d;
      sync_q    <= sync_d;
    end
  end

  assign count       = count_q;
  assign blank       = blank_q;
  assign active      = ~blank_q;
  assign sync        = sync_q;
  assign wrap        = wrap_q;
  assign line_match  = match_q;
  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;

endmodule

// File: doc/sync_axis_cntr.md
Name: sync_axis_cntr

Overview:
- Parametrised timing-axis counter for the VGA sync generator. One instance serves as the vertical axis (advanced by the horizontal row-done strobe); the same block serves a horizontal axis when `adv` is tied high.
- Counts `0..total`, produces blank, sync and active-area flags, a frame-wrap pulse and a programmable line-match pulse.
- Timing registers are double-buffered. A committed new configuration takes effect only at a frame boundary, after validation.

Parameters:
- W, 10, counter and config field width.
- SYNC_POL, 0, sync active level (0 = active-low, as VGA 640x480).
- DEF_VISIBLE, 480, reset value of shadow visible field.
- DEF_SYNC_START, 490, reset value of shadow sync-start field.
- DEF_SYNC_END, 492, reset value of shadow sync-end field.
- DEF_TOTAL, 524, reset value of shadow total field (last count; period = total+1).

Ports:
- clk  in  1  system pixel clock; all state on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- adv  in  1  count-advance enable; one step per clk cycle where adv=1.
- cfg  in  4*W  {total, sync_end, sync_start, visible}; visible in [W-1:0].
- cfg_commit  in  1  one-cycle request to adopt cfg at the next wrap.
- match_line  in  W  count value that raises line_match.
- count  out  W  current position.
- blank  out  1  1 when count >= visible.
- active  out  1  ~blank.
- sync  out  1  SYNC_POL when sync_start <= count < sync_end, else ~SYNC_POL.
- wrap  out  1  one-cycle pulse, the cycle after count returns to 0.
- line_match  out  1  one-cycle pulse, the cycle after count becomes match_line.
- cfg_pending  out  1  commit accepted, awaiting wrap.
- cfg_err  out  1  sticky: last applied commit was rejected.

Behaviour:
- Reset (async assert, sync release):
  - count=0, blank=0, active=1, sync=~SYNC_POL.
  - wrap=0, line_match=0, cfg_pending=0, cfg_err=0.
  - Shadow fields load the DEF_* values.
- Counting:
  - On a clk with adv=1: if count==shadow total, count<=0 (wrap event); else count<=count+1.
  - Arithmetic is W-bit. Counting never relies on W-bit overflow; total bounds it.
  - adv=0 holds all state. Pulses still deassert after one cycle.
- Decodes:
  - blank, active and sync are registered from the next count value and the next shadow fields, so they are coherent with count in the same cycle.
  - No extra latency relative to count.
- Pulses:
  - wrap=1 for exactly the one clk following a wrap event.
  - line_match=1 for the one clk following any advance where the new count == match_line.
  - match_line=0 matches at each wrap.
  - match_line > total never fires.
  - Both pulses may coincide.
- Commit handshake:
  - cfg_commit=1 sets cfg_pending and captures cfg into a staging register.
  - A later commit before the wrap overwrites staging (last wins).
- Apply at wrap event:
  - Validity rule: visible <= sync_start < sync_end <= total and total != 0.
  - If staging is valid, shadow <= staging and cfg_err <= 0.
  - Otherwise shadow is unchanged and cfg_err <= 1.
  - cfg_pending clears in either case.
  - The new shadow governs the decodes for count=0 of the new frame.
- Simultaneous commit and wrap in the same cycle:
  - The previous staging value is applied.
  - The new commit re-arms cfg_pending for the following wrap.
- Reset mid-frame or mid-pending:
  - All state returns to reset values.
  - Staging is discarded; shadow returns to DEF_*.

Test Plan:
- Reset defaults, adv=1 continuously: count 0..524 then 0. blank rises at count=480. sync=0 for counts 490,491 only. wrap pulses one cycle after count 524->0.
- Commit {7,6,5,4} mid-frame: cfg_pending=1 until wrap, then period becomes 8. blank=1 for counts 4..7; sync low at count 5 only; cfg_err=0.
- Commit invalid {7,5,6,4} (sync_end < sync_start): at wrap, shadow stays {7,6,5,4}, cfg_err=1, cfg_pending=0. A subsequent valid commit clears cfg_err at the following wrap.
- adv toggled 1,0,0,1 with config {7,6,5,4}: count advances only on adv=1 cycles. Set match_line=3: line_match pulses exactly once per frame, one cycle after count becomes 3.
- Commit asserted in the same cycle as the wrap event (count=7, adv=1): staged value applied, cfg_pending stays 1, new value applied at the next wrap.
- nreset asserted at count=5 with cfg_pending=1: outputs go to reset values immediately (asynchronously). After release the period is 525 (DEF_TOTAL 524 + 1) and cfg_pending=0.
